// File: rtl/demorgan_sweep_checker.sv
// Sweeps A/B through all four input pairs, samples the De Morgan gate outputs after a settle time and scores them.
// Run latency is 4*PASSES*(SETTLE_CYCLES+1)+1 cycles from start to done; start is ignored while a run is in progress.
module demorgan_sweep_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int PASSES        = 1,
  parameter int ERRCNT_W      = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic                A,
  output logic                B,
  input  logic [7:0]          obs,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [ERRCNT_W-1:0] err_count,
  output logic [1:0]          first_fail_vec,
  output logic [7:0]          first_fail_mask
);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    DONE
  } state_t;

  localparam logic [7:0]          SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0]          PASS_LAST   = 8'(PASSES - 1);
  localparam logic [ERRCNT_W-1:0] ERR_ONE     = ERRCNT_W'(1);

  state_t     state;
  logic [1:0] vec;
  logic [7:0] pass_idx;
  logic [7:0] settle_cnt;
  logic       fail_seen;

  logic [7:0] expected;
  logic [7:0] mask;
  logic       mismatch;
  logic       last_vec;

  // Packed {nA,nB,nAandnB,AandB,nAB,nAornB,AorB,nAorB} for each {A,B}.
  always_comb begin
    expected = 8'h00;
    case (vec)
      2'd0: expected = 8'hED;
      2'd1: expected = 8'h8E;
      2'd2: expected = 8'h4E;
      2'd3: expected = 8'h12;
      default: expected = 8'h00;
    endcase
  end

  assign mask     = obs ^ expected;
  assign mismatch = |mask;
  assign last_vec = (vec == 2'd3) && (pass_idx == PASS_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      vec             <= 2'd0;
      pass_idx        <= 8'd0;
      settle_cnt      <= 8'd0;
      fail_seen       <= 1'b0;
      A               <= 1'b0;
      B               <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_count       <= '0;
      first_fail_vec  <= 2'd0;
      first_fail_mask <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            err_count       <= '0;
            pass            <= 1'b0;
            first_fail_vec  <= 2'd0;
            first_fail_mask <= 8'd0;
            fail_seen       <= 1'b0;
            vec             <= 2'd0;
            pass_idx        <= 8'd0;
            settle_cnt      <= 8'd0;
            A               <= 1'b0;
            B               <= 1'b0;
            busy            <= 1'b1;
            state           <= DRIVE;
          end
        end

        DRIVE: begin
          settle_cnt <= settle_cnt + 8'd1;
          if (settle_cnt == SETTLE_LAST) begin
            state <= SAMPLE;
          end
        end

        SAMPLE: begin
          if (mismatch) begin
            if (err_count != '1) begin
              err_count <= err_count + ERR_ONE;
            end
            if (!fail_seen) begin
              first_fail_vec  <= vec;
              first_fail_mask <= mask;
              fail_seen       <= 1'b1;
            end
          end
          if (last_vec) begin
            // fail_seen does not yet include this cycle's compare.
            pass  <= !(fail_seen || mismatch);
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            if (vec == 2'd3) begin
              pass_idx <= pass_idx + 8'd1;
            end
            vec        <= vec + 2'd1;
            {A, B}     <= vec + 2'd1;
            settle_cnt <= 8'd0;
            state      <= DRIVE;
          end
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_demorgan_sweep_checker.sv
// Scoreboarded bench: three checker instances with different parameters, each driving a behavioural gate model
// with injectable faults; expected run results are queued at launch and popped by a monitor on every done pulse.
module tb_demorgan_sweep_checker;

  typedef struct {
    int d;
    int done_cyc;
    int err;
    int pass;
    int ffv;
    int ffm;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] start_s;
  logic [2:0] a_s, b_s, busy_s, done_s, pass_s;
  logic [7:0] obs_s [3];
  logic [7:0] err_s [3];
  logic [1:0] ffv_s [3];
  logic [7:0] ffm_s [3];
  logic [3:0] err0, err2;
  logic [1:0] err1;

  logic [7:0] xm  [3][4];
  logic [7:0] clr [3];

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   cur = 0;
  exp_t sbq [$];
  logic [1:0] walk [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic int settle_of(input int d);
    return (d == 2) ? 1 : 2;
  endfunction
  function automatic int passes_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 2 : 3);
  endfunction
  function automatic int errw_of(input int d);
    return (d == 1) ? 2 : 4;
  endfunction

  // Reference gate block written directly from the Boolean definitions.
  function automatic logic [7:0] gate(input logic a, input logic b);
    return {~a, ~b, ~a & ~b, a & b, ~(a & b), ~a | ~b, a | b, ~(a | b)};
  endfunction

  always_comb begin
    for (int d = 0; d < 3; d++) begin
      obs_s[d] = (gate(a_s[d], b_s[d]) & ~clr[d]) ^ xm[d][{a_s[d], b_s[d]}];
    end
  end

  assign err_s[0] = {4'b0, err0};
  assign err_s[1] = {6'b0, err1};
  assign err_s[2] = {4'b0, err2};

  demorgan_sweep_checker dut0 (
    .clk(clk), .reset(reset), .start(start_s[0]), .A(a_s[0]), .B(b_s[0]), .obs(obs_s[0]),
    .busy(busy_s[0]), .done(done_s[0]), .pass(pass_s[0]), .err_count(err0),
    .first_fail_vec(ffv_s[0]), .first_fail_mask(ffm_s[0])
  );

  demorgan_sweep_checker #(.SETTLE_CYCLES(2), .PASSES(2), .ERRCNT_W(2)) dut1 (
    .clk(clk), .reset(reset), .start(start_s[1]), .A(a_s[1]), .B(b_s[1]), .obs(obs_s[1]),
    .busy(busy_s[1]), .done(done_s[1]), .pass(pass_s[1]), .err_count(err1),
    .first_fail_vec(ffv_s[1]), .first_fail_mask(ffm_s[1])
  );

  demorgan_sweep_checker #(.SETTLE_CYCLES(1), .PASSES(3), .ERRCNT_W(4)) dut2 (
    .clk(clk), .reset(reset), .start(start_s[2]), .A(a_s[2]), .B(b_s[2]), .obs(obs_s[2]),
    .busy(busy_s[2]), .done(done_s[2]), .pass(pass_s[2]), .err_count(err2),
    .first_fail_vec(ffv_s[2]), .first_fail_mask(ffm_s[2])
  );

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", nm, act, act, exp, exp, cyc);
    end
  endtask

  // Expected run outcome: walk every vector of every pass and score the faulted gate output.
  function automatic exp_t model(input int d, input int acc);
    exp_t       e;
    int         hits;
    int         maxv;
    logic [1:0] vv;
    logic [7:0] ideal, seen, diff;
    e.d = d; e.ffv = 0; e.ffm = 0;
    hits = 0;
    for (int p = 0; p < passes_of(d); p++) begin
      for (int v = 0; v < 4; v++) begin
        vv    = v[1:0];
        ideal = gate(vv[1], vv[0]);
        seen  = (ideal & ~clr[d]) ^ xm[d][vv];
        diff  = seen ^ ideal;
        if (diff != 8'h00) begin
          if (hits == 0) begin
            e.ffv = v;
            e.ffm = int'(diff);
          end
          hits++;
        end
      end
    end
    maxv       = (1 << errw_of(d)) - 1;
    e.err      = (hits > maxv) ? maxv : hits;
    e.pass     = (hits == 0) ? 1 : 0;
    e.done_cyc = acc + 4 * passes_of(d) * (settle_of(d) + 1);
    return e;
  endfunction

  // Monitor: logs the A/B walk while busy and scores every done pulse against the queue head.
  always @(negedge clk) begin
    exp_t e;
    int   n;
    bit   ok;
    if (busy_s[cur] === 1'b1) walk.push_back({a_s[cur], b_s[cur]});
    for (int d = 0; d < 3; d++) begin
      if (done_s[d] === 1'b1) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_done: dut %0d pulsed done at cycle %0d, none expected", d, cyc);
        end else begin
          e = sbq.pop_front();
          chk("done_dut", d, e.d);
          chk("done_cycle", cyc, e.done_cyc);
          chk("err_count", int'(err_s[d]), e.err);
          chk("pass", int'(pass_s[d]), e.pass);
          chk("first_fail_vec", int'(ffv_s[d]), e.ffv);
          chk("first_fail_mask", int'(ffm_s[d]), e.ffm);
          chk("busy_in_done", int'(busy_s[d]), 0);
          n = 4 * passes_of(d) * (settle_of(d) + 1);
          chk("walk_len", walk.size(), n);
          if (walk.size() == n) begin
            ok = 1;
            for (int i = 0; i < n; i++) begin
              if (walk[i] !== 2'((i / (settle_of(d) + 1)) % 4)) ok = 0;
            end
            chk("walk_order", int'(ok), 1);
          end
        end
        walk.delete();
      end
    end
  end

  task automatic clear_faults(input int d);
    clr[d] = 8'h00;
    for (int v = 0; v < 4; v++) xm[d][v] = 8'h00;
  endtask

  task automatic launch(input int d, input bit hold, output int acc);
    int n;
    n = 0;
    @(negedge clk);
    while ((busy_s[d] || done_s[d]) && n < 200) begin
      @(negedge clk);
      n++;
    end
    cur = d;
    walk.delete();
    acc = cyc + 1;
    sbq.push_back(model(d, acc));
    start_s[d] = 1'b1;
    @(negedge clk);
    if (!hold) start_s[d] = 1'b0;
    chk("accept_busy", int'(busy_s[d]), 1);
    chk("accept_err_clear", int'(err_s[d]), 0);
    chk("accept_mask_clear", int'(ffm_s[d]), 0);
    chk("accept_pass_clear", int'(pass_s[d]), 0);
  endtask

  task automatic wait_done(input int d, input bit spam);
    bit seen;
    seen = 0;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      if (done_s[d]) begin
        seen = 1;
        break;
      end
      if (spam) start_s[d] = busy_s[d] ? 1'($urandom % 2) : 1'b0;
    end
    if (spam) start_s[d] = 1'b0;
    chk("done_seen", int'(seen), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int d;
    int mode;
    start_s = 3'b000;
    reset   = 1'b1;
    for (int i = 0; i < 3; i++) clear_faults(i);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 3; i++) begin
      chk("rst_A", int'(a_s[i]), 0);
      chk("rst_B", int'(b_s[i]), 0);
      chk("rst_busy", int'(busy_s[i]), 0);
      chk("rst_done", int'(done_s[i]), 0);
      chk("rst_pass", int'(pass_s[i]), 0);
      chk("rst_err", int'(err_s[i]), 0);
      chk("rst_ffv", int'(ffv_s[i]), 0);
      chk("rst_ffm", int'(ffm_s[i]), 0);
    end

    // Clean gate block, default parameters.
    launch(0, 0, acc);
    wait_done(0, 0);

    // AorB stuck at 0.
    clr[0] = 8'h02;
    launch(0, 0, acc);
    wait_done(0, 0);
    clear_faults(0);

    // Every output inverted on the two-pass, 2-bit counter instance.
    for (int v = 0; v < 4; v++) xm[1][v] = 8'hFF;
    launch(1, 0, acc);
    wait_done(1, 0);
    clear_faults(1);

    // Reset during the second SAMPLE abandons the run.
    for (int v = 0; v < 4; v++) xm[0][v] = 8'hFF;
    launch(0, 0, acc);
    repeat (5) @(negedge clk);
    chk("pre_reset_err", int'(err_s[0]), 1);
    reset = 1'b1;
    sbq.delete();
    @(negedge clk);
    reset = 1'b0;
    walk.delete();
    chk("abort_busy", int'(busy_s[0]), 0);
    chk("abort_A", int'(a_s[0]), 0);
    chk("abort_B", int'(b_s[0]), 0);
    chk("abort_err", int'(err_s[0]), 0);
    chk("abort_done", int'(done_s[0]), 0);
    repeat (20) @(negedge clk);
    clear_faults(0);
    launch(0, 0, acc);
    wait_done(0, 0);

    // start toggled throughout the run must not relaunch or add done pulses.
    launch(0, 0, acc);
    wait_done(0, 1);
    repeat (5) @(negedge clk);

    // Failing run followed by a clean one: launch checks the clearing.
    for (int v = 0; v < 4; v++) xm[0][v] = 8'h5A;
    launch(0, 0, acc);
    wait_done(0, 0);
    clear_faults(0);
    launch(0, 0, acc);
    wait_done(0, 0);

    // Short settle, three passes.
    launch(2, 0, acc);
    wait_done(2, 0);

    // start held high relaunches one IDLE cycle after DONE.
    launch(0, 1, acc);
    sbq.push_back(model(0, acc + 14));
    repeat (15) @(negedge clk);
    start_s[0] = 1'b0;
    wait_done(0, 0);

    for (int r = 0; r < 16; r++) begin
      d    = int'($urandom % 3);
      mode = int'($urandom % 4);
      clear_faults(d);
      case (mode)
        1: clr[d] = 8'(1 << ($urandom % 8));
        2: for (int v = 0; v < 4; v++) xm[d][v] = ($urandom % 2 == 1) ? 8'($urandom) : 8'h00;
        3: xm[d][$urandom % 4] = 8'(1 << ($urandom % 8));
        default: ;
      endcase
      launch(d, 0, acc);
      wait_done(d, 1'($urandom % 2));
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
